fifo_drain_ctrl: RTL and testbench

Read-side stage placed directly downstream of the fifo block. It converts the FIFO's empty/read_enable/read_data interface into a valid/ready stream. It absorbs the FIFO's one-cycle read latency in a small internal buffer. There is no combinational path from out_ready to fifo_read_enable, and a continuously ready consumer receives one word per cycle in steady state.

---
 rtl/fifo_drain_ctrl.sv | 150 +++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_drain_ctrl
//
// Read-side adapter that sits directly behind a synchronous FIFO. It turns the
// FIFO's empty / read_enable / read_data interface (one-cycle read latency)
// into a valid/ready stream. A small circular holding buffer absorbs the read
// latency. Reads are issued only from registered state plus the FIFO's empty
// flag, so there is no combinational path from out_ready to fifo_read_enable.
// With BUF_DEPTH >= 3 a continuously ready consumer gets one word per cycle.
//
// Parameters
//   WIDTH        data word width (must match the upstream FIFO)
//   BUF_DEPTH    holding entries, minimum 2; 3 or more gives full throughput
//   COUNT_WIDTH  width of the delivered-word counter
//
// Ports
//   clk               rising-edge clock
//   rstn              synchronous active-low reset (shared with the FIFO)
//   fifo_empty        FIFO empty flag
//   fifo_read_data    FIFO read data, valid the cycle after an accepted read
//   fifo_read_enable  read request to the FIFO
//   out_data          head-of-buffer word
//   out_valid         out_data holds a valid word
//   out_ready         consumer accepts the word this cycle
//   word_count        handshakes completed since reset (wraps)
// -----------------------------------------------------------------------------
module fifo_drain_ctrl #(
  parameter int WIDTH       = 4,
  parameter int BUF_DEPTH   = 3,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   fifo_empty,
  input  logic [WIDTH-1:0]       fifo_read_data,
  output logic                   fifo_read_enable,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);
  // Occupancy plus the in-flight read can reach BUF_DEPTH, so the sum is
  // evaluated one bit wider than the occupancy register.
  localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(BUF_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]       r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [OCC_W-1:0]       r_occ;        // words held in r_mem
  logic                   r_pend;       // read accepted last edge, data on bus now
  logic [WIDTH-1:0]       r_out_data;   // registered copy of the head word
  logic [COUNT_WIDTH-1:0] r_word_count;

  // ---------------------------------------------------------------------------
  // Combinational
  // ---------------------------------------------------------------------------
  logic [OCC_W:0]   w_fill;
  logic             w_pop;
  logic [PTR_W-1:0] w_head_inc;
  logic [PTR_W-1:0] w_tail_inc;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [WIDTH-1:0] w_out_data_nxt;

  // Buffer slots already committed: stored words plus the read in flight.
  assign w_fill = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_pend};

  // Issue a read only when its data is guaranteed a free slot on arrival.
  assign fifo_read_enable = rstn && !fifo_empty && (w_fill < DEPTH_EXT);

  assign out_valid = (r_occ != '0);
  assign out_data  = r_out_data;
  assign word_count = r_word_count;

  assign w_pop = out_valid && out_ready;

  assign w_head_inc = (r_head == LAST_PTR) ? '0 : r_head + PTR_W'(1);
  assign w_tail_inc = (r_tail == LAST_PTR) ? '0 : r_tail + PTR_W'(1);

  // occ + p never exceeds BUF_DEPTH and a pop needs occ >= 1, so this fits.
  assign w_occ_nxt = r_occ + OCC_W'(r_pend) - OCC_W'(w_pop);

  // The head word is kept in its own register so that out_data can hold its
  // last value after the buffer drains and reset to zero without having to
  // reset the storage array. Next head word:
  //   - pop with >= 2 stored: the entry behind the current head
  //   - pop with 1 stored and a word arriving: the arriving word
  //   - empty and a word arriving: the arriving word
  //   - otherwise: unchanged (keeps out_data stable until the pop)
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // it unassigned would infer a latch.
    w_out_data_nxt = r_out_data;
    if (w_pop) begin
      if (r_occ > OCC_W'(1)) begin
        w_out_data_nxt = r_mem[w_head_inc];
      end else if (r_pend) begin
        w_out_data_nxt = fifo_read_data;
      end
    end else if ((r_occ == '0) && r_pend) begin
      w_out_data_nxt = fifo_read_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the data array is deliberately not reset; validity is carried by
  // r_occ, which is reset, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (rstn && r_pend) begin
      r_mem[r_tail] <= fifo_read_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_occ        <= '0;
      r_pend       <= 1'b0;   // a read in flight is dropped; the FIFO resets too
      r_out_data   <= '0;
      r_word_count <= '0;
    end else begin
      r_pend     <= fifo_read_enable && !fifo_empty;
      r_occ      <= w_occ_nxt;
      r_out_data <= w_out_data_nxt;
      if (r_pend) begin
        r_tail <= w_tail_inc;
      end
      if (w_pop) begin
        r_head       <= w_head_inc;
        r_word_count <= r_word_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_drain_ctrl
//
// Self-checking bench for fifo_drain_ctrl. The upstream FIFO is modelled as a
// queue reacting to the DUT's read enable with one-cycle read latency. The
// expected stream behaviour comes from a queue-level model of the holding
// buffer (words held, read in flight) plus an end-to-end scoreboard of every
// word written into the FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_drain_ctrl;

  localparam int WIDTH = 4;
  localparam int DEPTH = 3;
  localparam int CW    = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_read_data;
  logic             fifo_read_enable;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    word_count;

  always #5 clk = ~clk;

  fifo_drain_ctrl #(
    .WIDTH      (WIDTH),
    .BUF_DEPTH  (DEPTH),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .fifo_empty      (fifo_empty),
    .fifo_read_data  (fifo_read_data),
    .fifo_read_enable(fifo_read_enable),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .word_count      (word_count)
  );

  int total = 0;
  int bad   = 0;

  // Upstream FIFO contents and end-to-end scoreboard
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] sent[$];

  // Holding-buffer model
  logic [WIDTH-1:0] mbuf[$];
  logic             m_pend;
  logic [WIDTH-1:0] m_last;
  logic [CW-1:0]    m_count;

  // Observed from DUT ports: reads accepted minus words popped
  int               outstanding;
  int               cyc;
  logic             prev_hold;
  logic [WIDTH-1:0] prev_data;

  // Streaming statistics
  int first_acc;
  int first_valid;
  int run_len;
  int max_run;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    sent.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the
  // FIFO model and the buffer model past the rising edge.
  task automatic cycle();
    logic             exp_ren;
    logic             exp_valid;
    logic             acc_dut;
    logic             pop_dut;
    logic             pop_m;
    logic             acc_m;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] want;
    @(negedge clk);
    exp_valid = (mbuf.size() != 0);
    exp_ren   = rstn && (fq.size() != 0) && ((mbuf.size() + int'(m_pend)) < DEPTH);
    check("rd_en", 32'(fifo_read_enable), 32'(exp_ren));
    check("valid", 32'(out_valid), 32'(exp_valid));
    check("data", 32'(out_data), 32'(m_last));
    check("count", 32'(word_count), 32'(m_count));
    if (prev_hold) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(prev_data));
    end
    acc_dut = fifo_read_enable && !fifo_empty && rstn;
    pop_dut = out_valid && out_ready && rstn;
    if (pop_dut) begin
      check("pop_has_word", 32'(sent.size() != 0), 32'd1);
      if (sent.size() != 0) begin
        want = sent.pop_front();
        check("order", 32'(out_data), 32'(want));
      end
    end
    if (acc_dut) outstanding++;
    if (pop_dut) outstanding--;
    check("occ_bound", 32'(outstanding <= DEPTH), 32'd1);
    if (acc_dut && first_acc < 0) first_acc = cyc;
    if (out_valid && first_valid < 0) first_valid = cyc;
    run_len = out_valid ? run_len + 1 : 0;
    if (run_len > max_run) max_run = run_len;
    prev_hold = out_valid && !out_ready && rstn;
    prev_data = out_data;
    pop_m = exp_valid && out_ready && rstn;
    acc_m = exp_ren;
    @(posedge clk);
    #1;
    cyc++;
    if (!rstn) begin
      fq.delete();
      sent.delete();
      mbuf.delete();
      m_pend         = 1'b0;
      m_last         = '0;
      m_count        = '0;
      outstanding    = 0;
      prev_hold      = 1'b0;
      fifo_read_data = '0;
      fifo_empty     = 1'b1;
    end else begin
      cap = fifo_read_data;
      if (pop_m) begin
        void'(mbuf.pop_front());
        m_count++;
      end
      if (m_pend) mbuf.push_back(cap);
      m_pend = acc_m;
      if (mbuf.size() != 0) m_last = mbuf[0];
      if (acc_dut) fifo_read_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget && sent.size() != 0; i++) cycle();
    check(tag, 32'(sent.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int remaining;
    logic tog;

    rstn           = 1'b0;
    out_ready      = 1'b0;
    fifo_empty     = 1'b0;   // non-empty during reset: enable must still be 0
    fifo_read_data = '0;
    m_pend         = 1'b0;
    m_last         = '0;
    m_count        = '0;
    outstanding    = 0;
    cyc            = 0;
    prev_hold      = 1'b0;
    prev_data      = '0;
    first_acc      = -1;
    first_valid    = -1;
    run_len        = 0;
    max_run        = 0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 32'(fifo_read_enable), 32'd0);
    @(posedge clk);
    #1;
    fifo_empty = 1'b1;
    rstn       = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);

    // 1: four words with a ready consumer
    for (int i = 1; i <= 4; i++) push(WIDTH'(i));
    drain("t1_drain", 30);
    check("t1_count", 32'(word_count), 32'd4);
    cycle();
    check("t1_rd_en_idle", 32'(fifo_read_enable), 32'd0);

    // 2: stalled consumer fills the buffer, one word stays in the FIFO
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(WIDTH'(i));
    repeat (8) cycle();
    check("t2_fifo_left", 32'(fq.size()), 32'd1);
    check("t2_in_dut", 32'(outstanding), 32'd3);
    check("t2_rd_en", 32'(fifo_read_enable), 32'd0);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_head", 32'(out_data), 32'd1);
    drain("t2_drain", 40);
    check("t2_count", 32'(word_count), 32'd8);
    cycle();

    // 3: continuous stream of 8 words, one write per cycle
    first_acc   = -1;
    first_valid = -1;
    run_len     = 0;
    max_run     = 0;
    out_ready   = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(WIDTH'(i));
      cycle();
    end
    drain("t3_drain", 20);
    check("t3_latency", 32'(first_valid - first_acc), 32'd2);
    check("t3_run", 32'(max_run), 32'd8);
    check("t3_count", 32'(word_count), 32'd16);

    // 4: alternating ready while streaming 1..6
    for (int i = 1; i <= 6; i++) push(WIDTH'(i));
    tog = 1'b1;
    for (int i = 0; i < 60 && sent.size() != 0; i++) begin
      out_ready = tog;
      tog       = ~tog;
      cycle();
    end
    check("t4_drain", 32'(sent.size()), 32'd0);
    check("t4_count", 32'(word_count), 32'd22);

    // 5: reset with two words held and one read in flight
    out_ready = 1'b0;
    for (int i = 5; i <= 8; i++) push(WIDTH'(i));
    for (int i = 0; i < 20 && !(mbuf.size() == 2 && m_pend); i++) cycle();
    check("t5_setup", 32'(outstanding), 32'd3);
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_count", 32'(word_count), 32'd0);
    check("t5_data", 32'(out_data), 32'd0);
    cycle();
    check("t5_rd_en", 32'(fifo_read_enable), 32'd0);
    push(WIDTH'(9));
    push(WIDTH'(10));
    drain("t5_drain", 20);
    check("t5_count2", 32'(word_count), 32'd2);

    // 6: random traffic up to 260 words in total since reset -> count wraps
    remaining = 258;
    for (int i = 0; i < 6000 && (remaining > 0 || sent.size() != 0); i++) begin
      if (remaining > 0 && $urandom_range(0, 2) != 0) begin
        push(WIDTH'($urandom));
        remaining--;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    check("t6_pushed", 32'(remaining), 32'd0);
    drain("t6_drain", 20);
    check("t6_wrap", 32'(word_count), 32'd4);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
